div_ctrl: RTL



---
 rtl/div_ctrl_pkg.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/div_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings and constants for the M-extension divide sequencer
package div_ctrl_pkg;

   localparam int DIV_DW = 32;
   localparam logic [31:0] QUO_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN      = 32'h8000_0000;

   typedef enum logic [1:0] {
      OP_DIV  = 2'd0,
      OP_DIVU = 2'd1,
      OP_REM  = 2'd2,
      OP_REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   // MULDIV decode info carries rem/unsigned flags; bit 0 of the op is "unsigned", bit 1 is "remainder"
   function automatic div_op_e muldiv_to_div_op(input logic is_rem, input logic is_unsigned);
      return div_op_e'({is_rem, is_unsigned});
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring divide iteration (combinational)
module div_step #(
   parameter int DW = 32
) (
   input  logic [DW:0]   rem_i,
   input  logic [DW-1:0] quo_i,
   input  logic [DW-1:0] dvsr_i,
   output logic [DW:0]   rem_o,
   output logic [DW-1:0] quo_o
);

   logic [DW+1:0] shifted;
   logic [DW+1:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[DW-1]};
      diff    = shifted - {2'b00, dvsr_i};
      // top bit of diff set means the trial subtract borrowed: restore
      if (diff[DW+1]) begin
         rem_o = shifted[DW:0];
         quo_o = {quo_i[DW-2:0], 1'b0};
      end else begin
         rem_o = diff[DW:0];
         quo_o = {quo_i[DW-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU/REM/REMU sequencer: accept, 32 restoring steps, sign fixup, result pulse
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DW    = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [1:0]    op_i,
   input  logic [DW-1:0] dividend_i,
   input  logic [DW-1:0] divisor_i,
   input  logic [4:0]    rd_waddr_i,
   input  logic          flush_i,
   output logic          busy_o,
   output logic          result_valid_o,
   output logic [DW-1:0] result_o,
   output logic [4:0]    rd_waddr_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   div_op_e          op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic [DW-1:0]    dvsr_q, dvsr_d;
   logic [DW:0]      rem_q, rem_d;
   logic [DW-1:0]    quo_q, quo_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [DW-1:0]    result_q, result_d;
   logic [4:0]       rd_out_q, rd_out_d;

   logic [DW:0]      step_rem;
   logic [DW-1:0]    step_quo;
   logic             signed_in, a_neg, b_neg, div0, ovf;
   logic [DW-1:0]    abs_a, abs_b;

   div_step #(.DW(DW)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      dvsr_d    = dvsr_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      result_d  = result_q;
      rd_out_d  = rd_out_q;

      signed_in = ~op_i[0];
      a_neg     = signed_in & dividend_i[DW-1];
      b_neg     = signed_in & divisor_i[DW-1];
      abs_a     = a_neg ? -dividend_i : dividend_i;
      abs_b     = b_neg ? -divisor_i : divisor_i;
      div0      = (divisor_i == '0);
      ovf       = signed_in && (dividend_i == INT_MIN) && (divisor_i == QUO_ALL_ONES);

      case (state_q)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               op_d    = div_op_e'(op_i);
               rd_d    = rd_waddr_i;
               dvsr_d  = abs_b;
               rem_d   = '0;
               quo_d   = abs_a;
               q_neg_d = a_neg ^ b_neg;
               r_neg_d = a_neg;
               cnt_d   = '0;
               // architectural special cases bypass the iteration entirely
               if (div0) begin
                  state_d  = ST_DONE;
                  result_d = op_i[1] ? dividend_i : QUO_ALL_ONES;
                  rd_out_d = rd_waddr_i;
               end else if (ovf) begin
                  state_d  = ST_DONE;
                  result_d = op_i[1] ? '0 : INT_MIN;
                  rd_out_d = rd_waddr_i;
               end else begin
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DW - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               if (op_q[1]) begin
                  result_d = r_neg_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];
               end else begin
                  result_d = q_neg_q ? -quo_q : quo_q;
               end
               rd_out_d = rd_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o         = (state_q != ST_IDLE);
   assign result_valid_o = (state_q == ST_DONE) && !flush_i;
   assign result_o       = result_q;
   assign rd_waddr_o     = rd_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_DIV;
         rd_q     <= '0;
         dvsr_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         dvsr_q   <= dvsr_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

endmodule
